// File: rtl/dmem_access_unit.sv
// Load/store initiator between the MEM-stage control and DataMemory.
// Sequences one access at a time and sign/zero-extends byte loads.
module dmem_access_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_LSU_start,
  input  logic [2:0]  i_LSU_op,
  input  logic [31:0] i_LSU_addr,
  input  logic [31:0] i_LSU_wData,
  output logic        o_LSU_busy,
  output logic        o_LSU_done,
  output logic        o_LSU_err,
  output logic [31:0] o_LSU_rData,
  output logic        o_DMem_we,
  output logic        o_DMem_sByte,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wData,
  input  logic [31:0] i_DMem_rData
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  localparam int unsigned WAIT_INIT_I = (RD_LATENCY > 32'd0) ? (RD_LATENCY - 32'd1) : 32'd0;
  localparam logic [3:0]  WAIT_INIT   = WAIT_INIT_I[3:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  lane_r;
  logic [3:0]  cnt_r;
  logic        op_illegal_s;
  logic        misaligned_s;
  logic        req_err_s;
  logic [31:0] load_result_s;

  // Little-endian lane select with sign or zero extension for byte loads.
  function automatic logic [31:0] load_extract(input logic [2:0] op,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    case (op)
      OP_LW:   load_extract = word;
      OP_LB:   load_extract = {{24{b[7]}}, b};
      default: load_extract = {24'h000000, b};
    endcase
  endfunction

  // Request legality, checked on the raw inputs while idle.
  always_comb begin
    op_illegal_s = 1'b1;
    misaligned_s = 1'b0;
    case (i_LSU_op)
      OP_LW, OP_SW:  begin
        op_illegal_s = 1'b0;
        misaligned_s = (i_LSU_addr[1:0] != 2'b00);
      end
      OP_LB, OP_LBU, OP_SB: op_illegal_s = 1'b0;
      default:       op_illegal_s = 1'b1;
    endcase
    req_err_s     = op_illegal_s | misaligned_s;
    load_result_s = load_extract(op_r, lane_r, i_DMem_rData);
  end

  // Access sequencer; every output is a register updated on the transitions.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      op_r         <= 3'b000;
      lane_r       <= 2'b00;
      cnt_r        <= 4'd0;
      o_LSU_busy   <= 1'b0;
      o_LSU_done   <= 1'b0;
      o_LSU_err    <= 1'b0;
      o_LSU_rData  <= 32'h0000_0000;
      o_DMem_we    <= 1'b0;
      o_DMem_sByte <= 1'b0;
      o_DMem_addr  <= 32'h0000_0000;
      o_DMem_wData <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_LSU_done   <= 1'b0;
          o_LSU_err    <= 1'b0;
          o_DMem_we    <= 1'b0;
          o_DMem_sByte <= 1'b0;
          if (i_LSU_start) begin
            op_r       <= i_LSU_op;
            lane_r     <= i_LSU_addr[1:0];
            o_LSU_busy <= 1'b1;
            if (req_err_s) begin
              state_r    <= S_DONE;
              o_LSU_done <= 1'b1;
              o_LSU_err  <= 1'b1;
            end else if (i_LSU_op[2]) begin
              state_r      <= S_ISSUE;
              o_DMem_we    <= 1'b1;
              o_DMem_addr  <= i_LSU_addr;
              o_DMem_sByte <= (i_LSU_op == OP_SB);
              o_DMem_wData <= (i_LSU_op == OP_SB) ? {24'h000000, i_LSU_wData[7:0]} : i_LSU_wData;
            end else begin
              state_r     <= S_ISSUE;
              o_DMem_addr <= {i_LSU_addr[31:2], 2'b00};
            end
          end else begin
            o_LSU_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          o_DMem_we    <= 1'b0;
          o_DMem_sByte <= 1'b0;
          if (op_r[2]) begin
            state_r    <= S_DONE;
            o_LSU_done <= 1'b1;
          end else if (RD_LATENCY == 32'd0) begin
            state_r     <= S_DONE;
            o_LSU_done  <= 1'b1;
            o_LSU_rData <= load_result_s;
          end else begin
            state_r <= S_WAIT;
            cnt_r   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= S_DONE;
            o_LSU_done  <= 1'b1;
            o_LSU_rData <= load_result_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_DONE: begin
          state_r    <= S_IDLE;
          o_LSU_done <= 1'b0;
          o_LSU_err  <= 1'b0;
          o_LSU_busy <= 1'b0;
        end
        default: begin
          state_r      <= S_IDLE;
          o_LSU_busy   <= 1'b0;
          o_LSU_done   <= 1'b0;
          o_LSU_err    <= 1'b0;
          o_DMem_we    <= 1'b0;
          o_DMem_sByte <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit at read latencies 0, 1 and 3.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start0, start1, start3;
  logic [2:0]  op_i;
  logic [31:0] addr_i, wdata_i;

  logic        busy0, done0, err0, we0, sb0;
  logic        busy1, done1, err1, we1, sb1;
  logic        busy3, done3, err3, we3, sb3;
  logic [31:0] rd0, daddr0, dwd0, rdata0;
  logic [31:0] rd1, daddr1, dwd1, rdata1;
  logic [31:0] rd3, daddr3, dwd3, rdata3;
  logic [31:0] p1, p2, p3;
  logic [31:0] mem [0:15];

  int tests = 0;
  int fails = 0;
  int we_cnt = 0, sbl_cnt = 0, done1_cnt = 0, done3_cnt = 0;
  logic [31:0] w_addr = 32'h0, w_wd = 32'h0, r_addr = 32'h0;
  logic        w_sb = 1'b0;

  always #5 clk = ~clk;

  dmem_access_unit #(.RD_LATENCY(0)) u_l0 (
    .clk(clk), .rstn(rstn), .i_LSU_start(start0), .i_LSU_op(op_i), .i_LSU_addr(addr_i),
    .i_LSU_wData(wdata_i), .o_LSU_busy(busy0), .o_LSU_done(done0), .o_LSU_err(err0),
    .o_LSU_rData(rd0), .o_DMem_we(we0), .o_DMem_sByte(sb0), .o_DMem_addr(daddr0),
    .o_DMem_wData(dwd0), .i_DMem_rData(rdata0));

  dmem_access_unit #(.RD_LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .i_LSU_start(start1), .i_LSU_op(op_i), .i_LSU_addr(addr_i),
    .i_LSU_wData(wdata_i), .o_LSU_busy(busy1), .o_LSU_done(done1), .o_LSU_err(err1),
    .o_LSU_rData(rd1), .o_DMem_we(we1), .o_DMem_sByte(sb1), .o_DMem_addr(daddr1),
    .o_DMem_wData(dwd1), .i_DMem_rData(rdata1));

  dmem_access_unit #(.RD_LATENCY(3)) u_l3 (
    .clk(clk), .rstn(rstn), .i_LSU_start(start3), .i_LSU_op(op_i), .i_LSU_addr(addr_i),
    .i_LSU_wData(wdata_i), .o_LSU_busy(busy3), .o_LSU_done(done3), .o_LSU_err(err3),
    .o_LSU_rData(rd3), .o_DMem_we(we3), .o_DMem_sByte(sb3), .o_DMem_addr(daddr3),
    .o_DMem_wData(dwd3), .i_DMem_rData(rdata3));

  // Latency-1 memory with byte-lane writes; the other two DUTs read an address-derived pattern.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (we1) begin
      if (sb1) begin
        case (daddr1[1:0])
          2'd0: mem[daddr1[5:2]][7:0]   <= dwd1[7:0];
          2'd1: mem[daddr1[5:2]][15:8]  <= dwd1[7:0];
          2'd2: mem[daddr1[5:2]][23:16] <= dwd1[7:0];
          default: mem[daddr1[5:2]][31:24] <= dwd1[7:0];
        endcase
      end else begin
        mem[daddr1[5:2]] <= dwd1;
      end
    end
    rdata1 <= mem[daddr1[5:2]];
    p1 <= daddr3 ^ 32'hA55A_5AA5;
    p2 <= p1;
    p3 <= p2;
  end
  assign rdata0 = daddr0 ^ 32'hA55A_5AA5;
  assign rdata3 = p3;

  always @(negedge clk) begin
    if (we1) begin
      we_cnt <= we_cnt + 1;
      w_addr <= daddr1;
      w_sb   <= sb1;
      w_wd   <= dwd1;
    end
    if (busy1 && !we1 && !done1) begin
      r_addr <= daddr1;
      if (sb1) sbl_cnt <= sbl_cnt + 1;
    end
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done3) done3_cnt <= done3_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input int sel, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rd);
    logic got;
    logic d;
    @(negedge clk);
    op_i = op; addr_i = addr; wdata_i = wd;
    start0 = (sel == 0); start1 = (sel == 1); start3 = (sel == 3);
    @(posedge clk);
    #1 start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
    got = 1'b0; lat = 0; err = 1'b0; rd = 32'h0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      d = (sel == 0) ? done0 : (sel == 1) ? done1 : done3;
      if (d) begin
        got = 1'b1;
        lat = k;
        err = (sel == 0) ? err0 : (sel == 1) ? err1 : err3;
        rd  = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd3;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout: no done from dut %0d op %b", sel, op);
    end
    #1;
  endtask

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [18];

  initial begin
    int lat;
    logic err;
    logic [31:0] rd, exp_wd, prev_daddr;
    int we0c, sb0c, d0;

    vt[0]  = '{1, 3'b100, 32'h4,  32'hDEADBEEF, 1'b0, 2, 32'h0000_0000};
    vt[1]  = '{1, 3'b000, 32'h4,  32'h0,        1'b0, 3, 32'hDEADBEEF};
    vt[2]  = '{1, 3'b001, 32'h7,  32'h0,        1'b0, 3, 32'hFFFFFFDE};
    vt[3]  = '{1, 3'b010, 32'h7,  32'h0,        1'b0, 3, 32'h000000DE};
    vt[4]  = '{1, 3'b001, 32'h5,  32'h0,        1'b0, 3, 32'hFFFFFFBE};
    vt[5]  = '{1, 3'b101, 32'h8,  32'h12345680, 1'b0, 2, 32'hFFFFFFBE};
    vt[6]  = '{1, 3'b001, 32'h8,  32'h0,        1'b0, 3, 32'hFFFFFF80};
    vt[7]  = '{1, 3'b000, 32'h8,  32'h0,        1'b0, 3, 32'h00000080};
    vt[8]  = '{1, 3'b000, 32'h6,  32'h0,        1'b1, 1, 32'h00000080};
    vt[9]  = '{1, 3'b011, 32'h0,  32'h0,        1'b1, 1, 32'h00000080};
    vt[10] = '{1, 3'b100, 32'h2,  32'h55,       1'b1, 1, 32'h00000080};
    vt[11] = '{1, 3'b010, 32'h4,  32'h0,        1'b0, 3, 32'h000000EF};
    vt[12] = '{1, 3'b111, 32'h4,  32'h0,        1'b1, 1, 32'h000000EF};
    vt[13] = '{0, 3'b000, 32'h10, 32'h0,        1'b0, 2, 32'hA55A5AB5};
    vt[14] = '{0, 3'b001, 32'h13, 32'h0,        1'b0, 2, 32'hFFFFFFA5};
    vt[15] = '{0, 3'b100, 32'h3,  32'h0,        1'b1, 1, 32'hFFFFFFA5};
    vt[16] = '{3, 3'b000, 32'h10, 32'h0,        1'b0, 5, 32'hA55A5AB5};
    vt[17] = '{3, 3'b010, 32'h10, 32'h0,        1'b0, 5, 32'h000000B5};

    rstn = 1'b0; start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
    op_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy",  {31'h0, busy1}, 32'h0);
    chk("reset done",  {31'h0, done1}, 32'h0);
    chk("reset err",   {31'h0, err1},  32'h0);
    chk("reset rData", rd1,            32'h0);
    chk("reset we",    {31'h0, we1},   32'h0);
    chk("reset sByte", {31'h0, sb1},   32'h0);
    chk("reset addr",  daddr1,         32'h0);
    chk("reset wData", dwd1,           32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      we0c = we_cnt; sb0c = sbl_cnt; prev_daddr = daddr1;
      run_req(vt[i].sel, vt[i].op, vt[i].addr, vt[i].wd, lat, err, rd);
      chk($sformatf("v%0d latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vt[i].err});
      chk($sformatf("v%0d rData", i), rd, vt[i].rd);
      if (vt[i].sel == 1) begin
        chk($sformatf("v%0d we cycles", i), we_cnt - we0c, (!vt[i].err && vt[i].op[2]) ? 1 : 0);
        if (vt[i].err) begin
          chk($sformatf("v%0d addr untouched", i), daddr1, prev_daddr);
        end else if (vt[i].op[2]) begin
          exp_wd = (vt[i].op == 3'b101) ? {24'h0, vt[i].wd[7:0]} : vt[i].wd;
          chk($sformatf("v%0d store addr", i), w_addr, vt[i].addr);
          chk($sformatf("v%0d store sByte", i), {31'h0, w_sb}, {31'h0, vt[i].op == 3'b101});
          chk($sformatf("v%0d store wData", i), w_wd, exp_wd);
        end else begin
          chk($sformatf("v%0d load addr", i), r_addr, {vt[i].addr[31:2], 2'b00});
          chk($sformatf("v%0d load sByte", i), sbl_cnt - sb0c, 0);
        end
      end
    end

    // start pulsed again while the first load is in WAIT
    d0 = done1_cnt;
    @(negedge clk);
    op_i = 3'b000; addr_i = 32'h4; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("busy ignore done count", done1_cnt - d0, 1);
    chk("busy ignore rData", rd1, 32'hDEADBEEF);

    // start held high: one acceptance per IDLE visit (edges 0, 4, 8)
    d0 = done1_cnt; we0c = we_cnt;
    @(negedge clk);
    op_i = 3'b010; addr_i = 32'h7; start1 = 1'b1;
    repeat (12) @(posedge clk);
    #1 start1 = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("held start done count", done1_cnt - d0, 3);
    chk("held start we count", we_cnt - we0c, 0);
    chk("held start rData", rd1, 32'h000000DE);

    // reset asserted while the latency-3 load sits in WAIT
    d0 = done3_cnt;
    @(negedge clk);
    op_i = 3'b000; addr_i = 32'h10; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset busy",  {31'h0, busy3}, 32'h0);
    chk("mid reset done",  {31'h0, done3}, 32'h0);
    chk("mid reset rData", rd3,            32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("mid reset no done", done3_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
